// File: rtl/dram_pkg.sv
// Shared DRAM bank definitions: default geometry and the bank FSM state encoding,
// used by both the write bank and the read bank model.
package dram_pkg;

    localparam int DEF_ROW_BITS   = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_ROWS   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACTIVATE  = 2'd2,
        WRITE     = 2'd3
    } bank_state_t;

endpackage

// File: rtl/dram_row_array.sv
// Row storage for one bank: NUM_ROWS x DATA_WIDTH flops with a synchronous write
// port, a combinational read port and a synchronous clear.
module dram_row_array
    import dram_pkg::*;
#(
    parameter int ROW_BITS   = DEF_ROW_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ROW_BITS-1:0]   wr_row,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ROW_BITS-1:0]   rd_row,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [NUM_ROWS];

    // Clear wins over a write in the same cycle, so an aborted WRITE leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    assign rd_data = mem[rd_row];

endmodule

// File: rtl/dram_bank_write.sv
// Write side of a single open-page DRAM bank: accepts one write request at a time and
// sequences PRECHARGE / ACTIVATE / WRITE depending on the currently open row.
module dram_bank_write
    import dram_pkg::*;
#(
    parameter int ROW_BITS   = DEF_ROW_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ROW_BITS-1:0]   row_num,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_valid,
    output logic                  input_ready,
    output logic                  write_done,
    output logic [ROW_BITS-1:0]   open_row,
    output logic                  open_row_valid,
    input  logic [ROW_BITS-1:0]   rd_row,
    output logic [DATA_WIDTH-1:0] rd_data
);

    bank_state_t           state_q;
    bank_state_t           next_state;
    logic [ROW_BITS-1:0]   req_row_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic [ROW_BITS-1:0]   open_row_q;
    logic                  open_row_valid_q;
    logic                  write_done_q;
    logic                  accept;
    logic                  wr_en;

    assign input_ready = (state_q == IDLE);
    assign accept      = input_valid && input_ready;
    assign wr_en       = (state_q == WRITE);

    // Hit/miss is decided against the incoming row, which is the row latched at this edge.
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!open_row_valid_q) begin
                        next_state = ACTIVATE;
                    end else if (open_row_q == row_num) begin
                        next_state = WRITE;
                    end else begin
                        next_state = PRECHARGE;
                    end
                end
            end
            PRECHARGE: next_state = ACTIVATE;
            ACTIVATE:  next_state = WRITE;
            WRITE:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            req_row_q        <= '0;
            req_data_q       <= '0;
            open_row_q       <= '0;
            open_row_valid_q <= 1'b0;
            write_done_q     <= 1'b0;
        end else begin
            state_q      <= next_state;
            write_done_q <= (state_q == WRITE);
            if (accept) begin
                req_row_q  <= row_num;
                req_data_q <= input_data;
            end
            // The row stays open after a write; only a miss closes it.
            if (state_q == PRECHARGE) begin
                open_row_valid_q <= 1'b0;
            end
            if (state_q == ACTIVATE) begin
                open_row_q       <= req_row_q;
                open_row_valid_q <= 1'b1;
            end
        end
    end

    assign write_done     = write_done_q;
    assign open_row       = open_row_q;
    assign open_row_valid = open_row_valid_q;

    dram_row_array #(
        .ROW_BITS   (ROW_BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_ROWS   (NUM_ROWS)
    ) u_rows (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_row  (req_row_q),
        .wr_data (req_data_q),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_dram_bank_write.sv
// Scoreboard bench for dram_bank_write: each accepted request pushes its expected
// completion edge and row; the write_done monitor pops and checks them.
module tb_dram_bank_write;
    import dram_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  row_num;
    logic [31:0] input_data;
    logic        input_valid;
    logic        input_ready;
    logic        write_done;
    logic [3:0]  open_row;
    logic        open_row_valid;
    logic [3:0]  rd_row;
    logic [31:0] rd_data;

    typedef struct {
        logic [3:0]  row;
        logic [31:0] data;
        int          done_edge;
    } exp_t;

    exp_t expQ[$];
    int   doneEdges[$];
    int   cyc;
    int   doneCount;
    int   compared;
    int   mismatched;
    bit   tbOpenValid;
    logic [3:0] tbOpenRow;
    int   snap;

    dram_bank_write dut (
        .clk            (clk),
        .reset          (reset),
        .row_num        (row_num),
        .input_data     (input_data),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .write_done     (write_done),
        .open_row       (open_row),
        .open_row_valid (open_row_valid),
        .rd_row         (rd_row),
        .rd_data        (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Called at a negedge; holds the request until accepted and returns at a negedge.
    task automatic applyStimulus(input logic [3:0] row, input logic [31:0] data, input bit hold);
        int  lat;
        bit  accepted;
        accepted    = 1'b0;
        row_num     = row;
        input_data  = data;
        input_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (input_ready) begin
                if (tbOpenValid && tbOpenRow == row) lat = 1;
                else if (!tbOpenValid)              lat = 2;
                else                                lat = 3;
                expQ.push_back('{row: row, data: data, done_edge: cyc + 1 + lat});
                tbOpenValid = 1'b1;
                tbOpenRow   = row;
                accepted    = 1'b1;
            end
            @(negedge clk);
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        if (!hold) input_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 12 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) checkOutput("done_timeout", 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkRow(input string tag, input logic [3:0] row, input logic [31:0] expected);
        rd_row = row;
        #1;
        checkOutput(tag, 64'(rd_data), 64'(expected));
    endtask

    always @(negedge clk) begin
        if (write_done) begin
            exp_t e;
            doneCount++;
            doneEdges.push_back(cyc);
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("done_edge", 64'(cyc), 64'(e.done_edge));
                checkOutput("done_open_row", 64'(open_row), 64'(e.row));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        cyc = 0; doneCount = 0; compared = 0; mismatched = 0;
        tbOpenValid = 1'b0; tbOpenRow = '0;
        reset = 1'b1; row_num = '0; input_data = '0; input_valid = 1'b0; rd_row = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(input_ready), 64'd1);
        checkOutput("rst_done", 64'(write_done), 64'd0);
        checkOutput("rst_open_valid", 64'(open_row_valid), 64'd0);
        checkOutput("rst_open_row", 64'(open_row), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Empty bank
        applyStimulus(4'd0, 32'd5, 1'b0);
        waitIdle();
        checkOutput("empty_open_row", 64'(open_row), 64'd0);
        checkOutput("empty_open_valid", 64'(open_row_valid), 64'd1);
        checkRow("empty_rd_row0", 4'd0, 32'd5);

        // Hit on row 8
        applyStimulus(4'd8, 32'h11, 1'b0);
        waitIdle();
        applyStimulus(4'd8, 32'd100, 1'b0);
        checkOutput("hit_ready_low", 64'(input_ready), 64'd0);
        @(negedge clk);
        checkOutput("hit_ready_back", 64'(input_ready), 64'd1);
        waitIdle();
        checkRow("hit_rd_row8", 4'd8, 32'd100);

        // Miss: row 15 open, write row 14
        applyStimulus(4'd15, 32'hAB, 1'b0);
        waitIdle();
        applyStimulus(4'd14, 32'd7, 1'b0);
        checkOutput("miss_st_pre", 64'(dut.state_q), 64'(PRECHARGE));
        @(negedge clk);
        checkOutput("miss_st_act", 64'(dut.state_q), 64'(ACTIVATE));
        @(negedge clk);
        checkOutput("miss_st_wr", 64'(dut.state_q), 64'(WRITE));
        waitIdle();
        checkOutput("miss_open_row", 64'(open_row), 64'd14);
        checkRow("miss_rd_row15", 4'd15, 32'hAB);
        checkRow("miss_rd_row14", 4'd14, 32'd7);

        // Request pulsed during PRECHARGE must be ignored
        applyStimulus(4'd2, 32'h22, 1'b0);
        row_num = 4'd3; input_data = 32'h33; input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);
        checkRow("ignore_rd_row3", 4'd3, 32'd0);
        checkRow("ignore_rd_row2", 4'd2, 32'h22);
        checkOutput("ignore_open_row", 64'(open_row), 64'd2);

        // Back-to-back hits on row 10 with valid held
        applyStimulus(4'd10, 32'd0, 1'b0);
        waitIdle();
        doneEdges.delete();
        applyStimulus(4'd10, 32'd1, 1'b1);
        applyStimulus(4'd10, 32'd2, 1'b1);
        applyStimulus(4'd10, 32'd3, 1'b0);
        waitIdle();
        checkOutput("b2b_count", 64'(doneEdges.size()), 64'd3);
        if (doneEdges.size() == 3) begin
            checkOutput("b2b_gap1", 64'(doneEdges[1] - doneEdges[0]), 64'd2);
            checkOutput("b2b_gap2", 64'(doneEdges[2] - doneEdges[1]), 64'd2);
        end
        checkRow("b2b_rd_row10", 4'd10, 32'd3);

        // Reset during ACTIVATE of a miss
        applyStimulus(4'd4, 32'h44, 1'b0);
        @(negedge clk);
        checkOutput("rstmid_st_act", 64'(dut.state_q), 64'(ACTIVATE));
        snap  = doneCount;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        tbOpenValid = 1'b0;
        tbOpenRow   = '0;
        checkOutput("rstmid_ready", 64'(input_ready), 64'd1);
        checkOutput("rstmid_open_valid", 64'(open_row_valid), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("rstmid_no_done", 64'(doneCount), 64'(snap));
        for (int r = 0; r < 16; r++) begin
            checkRow("rstmid_rd_zero", 4'(r), 32'd0);
        end

        checkOutput("sb_drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dram_bank_write.md
DRAM_BANK_WRITE -- requirements
Module: dram_bank_write

Interface
Parameters
REQ-001 The block SHALL take parameter ROW_BITS, default 4, the row address width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, the row data width.
REQ-003 The block SHALL take parameter NUM_ROWS, default 16, the number of rows (2**ROW_BITS).

Ports
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port row_num, input, ROW_BITS: the target row of the write request.
REQ-007 The block SHALL have port input_data, input, DATA_WIDTH: the write data.
REQ-008 The block SHALL have port input_valid, input, 1 bit: a write request is present.
REQ-009 The block SHALL have port input_ready, output, 1 bit: the bank accepts a request this cycle.
REQ-010 The block SHALL have port write_done, output, 1 bit: a one-cycle pulse when a write commits.
REQ-011 The block SHALL have port open_row, output, ROW_BITS: the currently open row.
REQ-012 The block SHALL have port open_row_valid, output, 1 bit: some row is open.
REQ-013 The block SHALL have port rd_row, input, ROW_BITS: the debug read address.
REQ-014 The block SHALL have port rd_data, output, DATA_WIDTH: the combinational contents of rd_row.

Function
REQ-015 A request SHALL be accepted at a rising edge only when input_valid=1 and input_ready=1; the block latches row_num and input_data at that edge.
REQ-016 input_valid while input_ready=0 SHALL be ignored; the requester must hold the request until it is accepted.
REQ-017 input_ready SHALL be 1 exactly when the FSM is in IDLE.
REQ-018 The FSM SHALL have the states IDLE, PRECHARGE, ACTIVATE and WRITE.
REQ-019 On accept with open_row_valid=1 and open_row equal to the latched row (row hit), the next state SHALL be WRITE.
REQ-020 On accept with open_row_valid=0 (bank empty), the next state SHALL be ACTIVATE.
REQ-021 On accept with open_row_valid=1 and open_row different from the latched row (row miss), the next state SHALL be PRECHARGE.
REQ-022 PRECHARGE SHALL last one cycle, set open_row_valid to 0 at its exiting edge, and then go to ACTIVATE.
REQ-023 ACTIVATE SHALL last one cycle, load open_row with the latched row and set open_row_valid to 1 at its exiting edge, and then go to WRITE.
REQ-024 WRITE SHALL last one cycle; at its exiting edge the block writes the latched data into the row array, sets write_done to 1 (registered) and goes to IDLE.
REQ-025 write_done SHALL be high for exactly one cycle per accepted request.
REQ-026 Counted from the accept edge N, write_done SHALL be high after edge N+1 on a hit, after edge N+2 on an empty bank, and after edge N+3 on a miss.
REQ-027 The row SHALL remain open after a write (open-page policy); no automatic precharge occurs.
REQ-028 A new request SHALL be acceptable in the same cycle that write_done is high (back-to-back: one hit write per 2 cycles).
REQ-029 rd_data SHALL reflect a committed write from the cycle after the WRITE exiting edge.
REQ-030 rd_data SHALL never show an uncommitted value.
REQ-031 Row index wrap SHALL NOT occur; all ROW_BITS values are valid rows.

Reset
REQ-032 While reset=1 at a rising edge, the FSM SHALL go to IDLE, with input_ready=1, write_done=0, open_row_valid=0, open_row=0, and every row cleared to 0.
REQ-033 Reset SHALL take priority over a simultaneous accept; the request is dropped.
REQ-034 Reset during PRECHARGE, ACTIVATE or WRITE SHALL abort the operation, write no data and produce no write_done pulse.

Structure
REQ-035 A shared package dram_pkg SHALL hold ROW_BITS, DATA_WIDTH and NUM_ROWS defaults and the FSM state enum, shared with the read bank model.
REQ-036 The storage SHALL be one sub-module dram_row_array: NUM_ROWS x DATA_WIDTH flops, one synchronous write port, one combinational read port, and synchronous clear.
REQ-037 The FSM, the request latches and the open-row tracking SHALL reside in dram_bank_write.

Verification
REQ-038 The bench SHALL cover the empty bank: after reset, write row 0, data 5, accepted at edge N -> write_done after N+2, open_row=0, open_row_valid=1, rd_data(row 0)=5.
REQ-039 The bench SHALL cover a hit: with row 8 open, write row 8, data 100 -> write_done after N+1, input_ready low for exactly 1 cycle.
REQ-040 The bench SHALL cover a miss: with row 15 open, write row 14, data 7 -> PRECHARGE, ACTIVATE, WRITE in order, write_done after N+3, open_row=14, rd_data(row 15) unchanged.
REQ-041 The bench SHALL cover back-to-back hits: valid held with rows 10, 10, 10 and data 1, 2, 3 -> three write_done pulses 2 cycles apart, final rd_data(row 10)=3.
REQ-042 The bench SHALL cover reset mid-miss: reset asserted during ACTIVATE -> no write_done, all rd_data=0, open_row_valid=0, input_ready=1 the cycle after.
REQ-043 The bench SHALL cover an ignored request: input_valid pulsed during PRECHARGE with row 3 -> not accepted, rd_data(row 3) stays 0.
